// File: rtl/sev_seg_display_mux_if.sv
// Display-side bundle for the seven-segment scanner: the value to show in,
// and the registered segment/digit drives out.
interface sev_seg_display_mux_if;
  logic [31:0] data_in;
  logic [6:0]  LED_Out;
  logic [7:0]  LED_Control;

  modport master (
    output data_in,
    input  LED_Out,
    input  LED_Control
  );

  modport slave (
    input  data_in,
    output LED_Out,
    output LED_Control
  );
endinterface

// File: rtl/sev_seg_display_mux.sv
// Time-multiplexed 8-digit hex driver for a seven-segment display: one digit
// enabled at a time, rotating every REFRESH_DIV clocks, outputs registered.
module sev_seg_display_mux #(
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  sev_seg_display_mux_if.slave  io_disp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0] AN_BLANK  = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;

  logic [3:0] w_nibble;
  logic [6:0] w_segLow;
  logic [7:0] w_anLow;

  // Segment patterns are held active-low {a..g}; polarity is applied afterwards.
  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  always_comb begin
    w_nibble = io_disp.data_in[{r_idx, 2'b00} +: 4];
    w_segLow = decodeHex(w_nibble);
    w_anLow  = ~(8'b0000_0001 << r_idx);
  end

  // Outputs reflect the pre-update index, so they trail idx by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
      r_an  <= AN_BLANK;
      r_seg <= SEG_BLANK;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_an  <= AN_ACTIVE_LOW  ? w_anLow  : ~w_anLow;
      r_seg <= SEG_ACTIVE_LOW ? w_segLow : ~w_segLow;
    end
  end

  assign io_disp.LED_Control = r_an;
  assign io_disp.LED_Out     = r_seg;

endmodule

// File: tb/tb_sev_seg_display_mux.sv
// Directed bench for sev_seg_display_mux: active-low and active-high builds
// at REFRESH_DIV=4, plus an active-low build at REFRESH_DIV=1.
module tb_sev_seg_display_mux;

  typedef struct {
    logic [31:0] data;
    int          cycle;
    logic [7:0]  expAn;
    logic [6:0]  expSeg;
  } vec_t;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk;
  logic        clkEn;
  logic        rst;
  logic [31:0] dataIn;
  int          cyc;
  int          checks;
  int          errors;
  vec_t        vecs[$];

  sev_seg_display_mux_if busL ();
  sev_seg_display_mux_if busH ();
  sev_seg_display_mux_if bus1 ();

  assign busL.data_in = dataIn;
  assign busH.data_in = dataIn;
  assign bus1.data_in = dataIn;

  sev_seg_display_mux #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
    dutL (.clk(clk), .rst(rst), .io_disp(busL));
  sev_seg_display_mux #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
    dutH (.clk(clk), .rst(rst), .io_disp(busH));
  sev_seg_display_mux #(.REFRESH_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
    dut1 (.clk(clk), .rst(rst), .io_disp(bus1));

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clkEn) clk = ~clk;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkBlank();
    checkOutput("blankL_an",  busL.LED_Control,     8'hFF);
    checkOutput("blankL_seg", {1'b0, busL.LED_Out}, 8'h7F);
    checkOutput("blankH_an",  busH.LED_Control,     8'h00);
    checkOutput("blankH_seg", {1'b0, busH.LED_Out}, 8'h00);
    checkOutput("blank1_an",  bus1.LED_Control,     8'hFF);
    checkOutput("blank1_seg", {1'b0, bus1.LED_Out}, 8'h7F);
  endtask

  task automatic checkDiv4(input string name, input logic [7:0] expAn,
                           input logic [6:0] expSeg);
    checkOutput({name, "_anL"},  busL.LED_Control,     expAn);
    checkOutput({name, "_segL"}, {1'b0, busL.LED_Out}, {1'b0, expSeg});
    checkOutput({name, "_anH"},  busH.LED_Control,     ~expAn);
    checkOutput({name, "_segH"}, {1'b0, busH.LED_Out}, {1'b0, ~expSeg});
  endtask

  // One clock; outside reset, one-hot checks plus the REFRESH_DIV=1 model.
  task automatic tick();
    int digit;
    @(posedge clk);
    @(negedge clk);
    if (!rst) begin
      cyc++;
      digit = (cyc - 1) % 8;
      checkOutput("onehotL", 8'($countones(~busL.LED_Control)), 8'd1);
      checkOutput("onehotH", 8'($countones(busH.LED_Control)),  8'd1);
      checkOutput("div1_an", bus1.LED_Control, ~(8'd1 << digit));
      checkOutput("div1_seg", {1'b0, bus1.LED_Out},
                  {1'b0, SEG_CODE[dataIn[4*digit +: 4]]});
    end
  endtask

  task automatic restartScan();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.cycle <= cyc) restartScan();
    dataIn = v.data;
    while (cyc < v.cycle) tick();
    checkDiv4("table", v.expAn, v.expSeg);
  endtask

  initial begin
    clkEn  = 1'b0;
    rst    = 1'b0;
    dataIn = 32'h0;
    cyc    = 0;
    checks = 0;
    errors = 0;

    // Frame walk over 12345678: digit k shown on cycles 4k+1..4k+4.
    vecs.push_back('{32'h12345678,  1, 8'hFE, 7'b0000000});
    vecs.push_back('{32'h12345678,  4, 8'hFE, 7'b0000000});
    vecs.push_back('{32'h12345678,  5, 8'hFD, 7'b0001111});
    vecs.push_back('{32'h12345678,  8, 8'hFD, 7'b0001111});
    vecs.push_back('{32'h12345678,  9, 8'hFB, 7'b0100000});
    vecs.push_back('{32'h12345678, 13, 8'hF7, 7'b0100100});
    vecs.push_back('{32'h12345678, 17, 8'hEF, 7'b1001100});
    vecs.push_back('{32'h12345678, 21, 8'hDF, 7'b0000110});
    vecs.push_back('{32'h12345678, 25, 8'hBF, 7'b0010010});
    vecs.push_back('{32'h12345678, 29, 8'h7F, 7'b1001111});
    vecs.push_back('{32'h12345678, 32, 8'h7F, 7'b1001111});
    vecs.push_back('{32'h12345678, 33, 8'hFE, 7'b0000000});
    // FEDCBA90 covers 0 and 9..F.
    vecs.push_back('{32'hFEDCBA90,  2, 8'hFE, 7'b0000001});
    vecs.push_back('{32'hFEDCBA90,  6, 8'hFD, 7'b0000100});
    vecs.push_back('{32'hFEDCBA90, 10, 8'hFB, 7'b0001000});
    vecs.push_back('{32'hFEDCBA90, 14, 8'hF7, 7'b1100000});
    vecs.push_back('{32'hFEDCBA90, 18, 8'hEF, 7'b0110001});
    vecs.push_back('{32'hFEDCBA90, 22, 8'hDF, 7'b1000010});
    vecs.push_back('{32'hFEDCBA90, 26, 8'hBF, 7'b0110000});
    vecs.push_back('{32'hFEDCBA90, 30, 8'h7F, 7'b0111000});

    // Reset with the clock stopped must blank the outputs on its own.
    #12 rst = 1'b1;
    #1 checkBlank();
    clkEn = 1'b1;
    tick();
    tick();
    checkBlank();
    rst = 1'b0;
    cyc = 0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Data change while digit 3 is enabled shows on the very next edge.
    restartScan();
    dataIn = 32'h12345678;
    while (cyc < 13) tick();
    checkDiv4("d3_before", 8'hF7, 7'b0100100);
    dataIn = 32'h0;
    tick();
    checkDiv4("d3_after", 8'hF7, 7'b0000001);

    // Reset mid-frame at digit 5, between clock edges.
    restartScan();
    dataIn = 32'h12345678;
    while (cyc < 22) tick();
    checkDiv4("d5_run", 8'hDF, 7'b0000110);
    #2 rst = 1'b1;
    #1 checkBlank();
    tick();
    checkBlank();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkDiv4("restart_d0", 8'hFE, 7'b0000000);
    end
    tick();
    checkDiv4("restart_d1", 8'hFD, 7'b0001111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
